// File: rtl/dmem_sized_wait_pkg.sv
// Shared types for the sized data memory: access-size codes, FSM states, captured request, error rule.
package dmem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef struct packed {
      logic        rd;
      logic        wr;
      logic [1:0]  size;
      logic        sign_ext;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;

   // A request is rejected when it is not exactly one of read/write, uses the reserved size, or is misaligned.
   function automatic logic req_err(input logic rd, input logic wr, input logic [1:0] size,
                                    input logic [1:0] addr_lo);
      req_err = (rd == wr) || (size == SZ_RSVD) ||
                ((size == SZ_HALF) && addr_lo[0]) ||
                ((size == SZ_WORD) && (addr_lo != 2'b00));
   endfunction

endpackage

// File: rtl/dmem_sized_wait_if.sv
// Request/response bundle between the MEM-stage controller (master) and the data memory (slave).
interface dmem_sized_wait_if;
   logic        req_valid;
   logic        req_ready;
   logic        mem_read;
   logic        mem_write;
   logic [1:0]  size;
   logic        sign_ext;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        resp_valid;
   logic        resp_err;
   logic [31:0] rdata;

   modport master (
      output req_valid, mem_read, mem_write, size, sign_ext, addr, wdata,
      input  req_ready, resp_valid, resp_err, rdata
   );

   modport slave (
      input  req_valid, mem_read, mem_write, size, sign_ext, addr, wdata,
      output req_ready, resp_valid, resp_err, rdata
   );
endinterface

// File: rtl/dmem_sized_wait_byte_array.sv
// Byte-wide storage, no reset: 4-lane write (lane 0 at waddr, big-endian) and combinational 4-byte read.
// Lane i lives at base+i and carries data bits [31-8i -: 8]; indices wrap at the top of the array.
module dmem_byte_array #(
   parameter int ADDR_BITS = 8
) (
   input  logic                 clk,
   input  logic [3:0]           we,
   input  logic [ADDR_BITS-1:0] waddr,
   input  logic [31:0]          wdata,
   input  logic [ADDR_BITS-1:0] raddr,
   output logic [31:0]          rdata
);
   localparam int DEPTH = 2 ** ADDR_BITS;

   logic [7:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (we[i]) begin
            mem[waddr + ADDR_BITS'(i)] <= wdata[31-8*i -: 8];
         end
      end
   end

   always_comb begin
      rdata = '0;
      for (int i = 0; i < 4; i++) begin
         rdata[31-8*i -: 8] = mem[raddr + ADDR_BITS'(i)];
      end
   end

endmodule

// File: rtl/dmem_sized_wait.sv
// Big-endian MIPS data memory (lb/lbu/lh/lhu/lw/sb/sh/sw); response pulses 1+WAIT_STATES cycles after accept.
// req_ready is high only in IDLE, so one access completes every 2+WAIT_STATES cycles at best.
module dmem_sized_wait
   import dmem_pkg::*;
#(
   parameter int ADDR_BITS   = 8,
   parameter int WAIT_STATES = 0,
   parameter int DATA_W      = 32
) (
   input logic              clk,
   input logic              rst,
   dmem_sized_wait_if.slave bus
);
   localparam logic [3:0] LAST_WAIT = 4'(WAIT_STATES - 1);

   if (DATA_W != 32) begin : g_bad_data_w
      $error("dmem_sized_wait: DATA_W must be 32");
   end
   if ((WAIT_STATES < 0) || (WAIT_STATES > 15)) begin : g_bad_wait
      $error("dmem_sized_wait: WAIT_STATES must be 0..15");
   end

   state_t               state;
   logic [3:0]           wait_cnt;
   req_t                 req_q;
   req_t                 cur;
   logic                 accept;
   logic                 enter_resp;
   logic                 commit;
   logic                 cur_err;
   logic [31:0]          raw;
   logic [31:0]          ext;
   logic [3:0]           lane_we;
   logic [31:0]          lane_dat;
   logic                 unused_bits;

   assign accept = bus.req_valid && bus.req_ready;

   // With zero wait states RESP is entered on the accept edge itself, so the read
   // and error check must look at the live request rather than the captured copy.
   always_comb begin
      if (state == IDLE) begin
         cur = '{rd: bus.mem_read, wr: bus.mem_write, size: bus.size,
                 sign_ext: bus.sign_ext, addr: bus.addr, wdata: bus.wdata};
      end else begin
         cur = req_q;
      end
   end

   assign cur_err    = req_err(cur.rd, cur.wr, cur.size, cur.addr[1:0]);
   assign enter_resp = ((state == IDLE) && accept && (WAIT_STATES == 0)) ||
                       ((state == WAIT) && (wait_cnt == LAST_WAIT));
   // Reset in the RESP cycle suppresses the commit.
   assign commit     = (state == RESP) && !rst && req_q.wr && !bus.resp_err;

   always_comb begin
      lane_we  = '0;
      lane_dat = '0;
      case (req_q.size)
         SZ_BYTE: begin
            lane_we  = 4'b0001;
            lane_dat = {req_q.wdata[7:0], 24'h0};
         end
         SZ_HALF: begin
            lane_we  = 4'b0011;
            lane_dat = {req_q.wdata[15:0], 16'h0};
         end
         SZ_WORD: begin
            lane_we  = 4'b1111;
            lane_dat = req_q.wdata;
         end
         default: ;
      endcase
      if (!commit) begin
         lane_we = '0;
      end
   end

   always_comb begin
      case (cur.size)
         SZ_BYTE: ext = {{24{cur.sign_ext & raw[31]}}, raw[31:24]};
         SZ_HALF: ext = {{16{cur.sign_ext & raw[31]}}, raw[31:16]};
         default: ext = raw;
      endcase
   end

   dmem_byte_array #(.ADDR_BITS(ADDR_BITS)) u_array (
      .clk   (clk),
      .we    (lane_we),
      .waddr (req_q.addr[ADDR_BITS-1:0]),
      .wdata (lane_dat),
      .raddr (cur.addr[ADDR_BITS-1:0]),
      .rdata (raw)
   );

   always_ff @(posedge clk) begin
      if ((state == IDLE) && accept) begin
         req_q <= cur;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         wait_cnt       <= '0;
         bus.req_ready  <= 1'b1;
         bus.resp_valid <= 1'b0;
         bus.resp_err   <= 1'b0;
         bus.rdata      <= '0;
      end else begin
         bus.resp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  bus.req_ready <= 1'b0;
                  wait_cnt      <= '0;
                  state         <= (WAIT_STATES == 0) ? RESP : WAIT;
               end
            end
            WAIT: begin
               if (wait_cnt == LAST_WAIT) begin
                  state <= RESP;
               end else begin
                  wait_cnt <= wait_cnt + 4'd1;
               end
            end
            RESP: begin
               state         <= IDLE;
               bus.req_ready <= 1'b1;
            end
            default: begin
               state         <= IDLE;
               bus.req_ready <= 1'b1;
            end
         endcase
         if (enter_resp) begin
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= cur_err;
            bus.rdata      <= (cur_err || !cur.rd) ? 32'h0 : ext;
         end
      end
   end

   assign unused_bits = ^{cur.wdata, cur.addr[31:ADDR_BITS], req_q.addr[31:ADDR_BITS],
                          req_q.rd, req_q.sign_ext};

endmodule

// File: tb/tb_dmem_sized_wait.sv
// Drives a zero-wait and a three-wait instance with directed and random accesses against a byte-array model.
module tb_dmem_sized_wait;
   import dmem_pkg::*;

   logic clk = 1'b0;
   logic rst0;
   logic rst3;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   last_resp_cyc = 0;
   logic [7:0] mref [2][256];

   dmem_sized_wait_if b0();
   dmem_sized_wait_if b3();

   dmem_sized_wait #(.ADDR_BITS(8), .WAIT_STATES(0), .DATA_W(32)) dut0 (
      .clk(clk), .rst(rst0), .bus(b0));
   dmem_sized_wait #(.ADDR_BITS(8), .WAIT_STATES(3), .DATA_W(32)) dut3 (
      .clk(clk), .rst(rst3), .bus(b3));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int sel, input bit v, input bit rd, input bit wr, input logic [1:0] sz,
                        input bit sx, input logic [31:0] a, input logic [31:0] wd);
      if (sel == 0) begin
         b0.req_valid = v; b0.mem_read = rd; b0.mem_write = wr; b0.size = sz;
         b0.sign_ext = sx; b0.addr = a; b0.wdata = wd;
      end else begin
         b3.req_valid = v; b3.mem_read = rd; b3.mem_write = wr; b3.size = sz;
         b3.sign_ext = sx; b3.addr = a; b3.wdata = wd;
      end
   endtask

   function automatic logic get_ready(input int sel);
      return (sel == 0) ? b0.req_ready : b3.req_ready;
   endfunction
   function automatic logic get_rv(input int sel);
      return (sel == 0) ? b0.resp_valid : b3.resp_valid;
   endfunction
   function automatic logic get_err(input int sel);
      return (sel == 0) ? b0.resp_err : b3.resp_err;
   endfunction
   function automatic logic [31:0] get_rdata(input int sel);
      return (sel == 0) ? b0.rdata : b3.rdata;
   endfunction

   // Expected outcome from the architectural rules: byte count 2**size, big-endian, two's-complement extend.
   function automatic void model_calc(input int sel, input bit rd, input bit wr, input logic [1:0] sz,
                                      input bit sx, input logic [31:0] a,
                                      output bit err, output logic [31:0] d);
      int n;
      int idx;
      logic [31:0] v;
      err = (rd == wr) || (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
      d = 32'h0;
      if (!err && rd) begin
         n   = 1 << sz;
         idx = int'(a % 256);
         v   = 32'h0;
         for (int k = 0; k < n; k++) v = (v << 8) | 32'(mref[sel][(idx + k) % 256]);
         if (sx && n < 4 && v >= 32'(1 << (8 * n - 1))) v = v - 32'(1 << (8 * n));
         d = v;
      end
   endfunction

   task automatic model_write(input int sel, input logic [1:0] sz, input logic [31:0] a,
                              input logic [31:0] wd);
      int n;
      int idx;
      n   = 1 << sz;
      idx = int'(a % 256);
      for (int k = 0; k < n; k++) mref[sel][(idx + k) % 256] = 8'(wd >> (8 * (n - 1 - k)));
   endtask

   task automatic xact(input int sel, input bit rd, input bit wr, input logic [1:0] sz, input bit sx,
                       input logic [31:0] a, input logic [31:0] wd, input bit hold,
                       output logic [31:0] got);
      int n;
      int ws;
      bit exp_err;
      logic [31:0] exp_dat;
      string p;
      ws = (sel == 0) ? 0 : 3;
      p  = $sformatf("s%0d_a%08h_sz%0d_r%0dw%0d", sel, a, sz, rd, wr);
      model_calc(sel, rd, wr, sz, sx, a, exp_err, exp_dat);
      drive(sel, 1'b1, rd, wr, sz, sx, a, wd);
      n = 0;
      while (!get_ready(sel) && n < 50) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      if (!hold) drive(sel, 1'b0, 1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
                       $urandom, $urandom);
      n = 0;
      while (!get_rv(sel) && n < 50) begin
         check({p, "_rdy_wait"}, 32'(get_ready(sel)), 32'd0);
         @(posedge clk); #1; n++;
      end
      last_resp_cyc = cyc;
      got = get_rdata(sel);
      check({p, "_lat"}, 32'(n), 32'(ws));
      check({p, "_err"}, 32'(get_err(sel)), 32'(exp_err));
      if (exp_err || (rd && !wr)) check({p, "_rdata"}, got, exp_dat);
      check({p, "_rdy_resp"}, 32'(get_ready(sel)), 32'd0);
      if (!hold) drive(sel, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
      @(posedge clk); #1;
      check({p, "_pulse"}, 32'(get_rv(sel)), 32'd0);
      check({p, "_rdy_back"}, 32'(get_ready(sel)), 32'd1);
      if (!exp_err && wr) model_write(sel, sz, a, wd);
   endtask

   initial begin
      logic [31:0] got;
      logic [31:0] prior;
      int t0;
      int n;
      int r;
      bit seen;
      bit rd;
      bit wr;
      bit b;
      logic [1:0] sz;
      logic [31:0] a;

      drive(0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
      drive(1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
      rst0 = 1'b1; rst3 = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready0", 32'(b0.req_ready), 32'd1);
      check("rst_rv0", 32'(b0.resp_valid), 32'd0);
      check("rst_err0", 32'(b0.resp_err), 32'd0);
      check("rst_rdata0", b0.rdata, 32'h0);
      check("rst_ready3", 32'(b3.req_ready), 32'd1);
      check("rst_rdata3", b3.rdata, 32'h0);
      rst0 = 1'b0; rst3 = 1'b0;

      for (int s = 0; s < 2; s++)
         for (int w = 0; w < 64; w++) xact(s, 1'b0, 1'b1, SZ_WORD, 1'b0, 32'(w * 4), $urandom, 1'b0, got);

      xact(0, 0, 1, SZ_WORD, 0, 32'h14, 32'h11223344, 0, got);
      xact(0, 1, 0, SZ_WORD, 0, 32'h14, 32'h0, 0, got);
      check("lw_0x14", got, 32'h11223344);
      xact(0, 1, 0, SZ_BYTE, 0, 32'h15, 32'h0, 0, got);
      check("lbu_0x15", got, 32'h00000022);

      xact(0, 0, 1, SZ_BYTE, 0, 32'h20, 32'h80, 0, got);
      xact(0, 1, 0, SZ_BYTE, 1, 32'h20, 32'h0, 0, got);
      check("lb_0x20", got, 32'hFFFFFF80);
      xact(0, 1, 0, SZ_BYTE, 0, 32'h20, 32'h0, 0, got);
      check("lbu_0x20", got, 32'h00000080);
      xact(0, 0, 1, SZ_HALF, 0, 32'h20, 32'h8001, 0, got);
      xact(0, 1, 0, SZ_HALF, 1, 32'h20, 32'h0, 0, got);
      check("lh_0x20", got, 32'hFFFF8001);
      xact(0, 1, 0, SZ_HALF, 0, 32'h20, 32'h0, 0, got);
      check("lhu_0x20", got, 32'h00008001);

      xact(0, 1, 0, SZ_WORD, 0, 32'h13, 32'h0, 0, got);
      check("lw_mis_rdata", got, 32'h0);
      xact(0, 0, 1, SZ_HALF, 0, 32'h21, 32'h5A5A, 0, got);
      xact(0, 1, 0, SZ_WORD, 0, 32'h20, 32'h0, 0, got);
      check("sh_mis_nowrite", {16'h0, got[31:16]}, 32'h00008001);
      xact(0, 1, 0, SZ_RSVD, 0, 32'h20, 32'h0, 0, got);
      xact(0, 1, 1, SZ_WORD, 0, 32'h24, 32'h12345678, 0, got);
      xact(0, 0, 0, SZ_WORD, 0, 32'h24, 32'h0, 0, got);

      xact(0, 0, 1, SZ_WORD, 0, 32'h100, 32'hCAFEBABE, 0, got);
      xact(0, 1, 0, SZ_WORD, 0, 32'h0, 32'h0, 0, got);
      check("wrap_lw_0x0", got, 32'hCAFEBABE);

      xact(1, 1, 0, SZ_WORD, 0, 32'h40, 32'h0, 1, got);
      t0 = last_resp_cyc;
      xact(1, 1, 0, SZ_WORD, 0, 32'h40, 32'h0, 0, got);
      check("s1_throughput", 32'(last_resp_cyc - t0), 32'd5);

      prior = {mref[1][64], mref[1][65], mref[1][66], mref[1][67]};
      drive(1, 1'b1, 1'b0, 1'b1, SZ_WORD, 1'b0, 32'h40, 32'hDEADBEEF);
      n = 0;
      while (!b3.req_ready && n < 50) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      drive(1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
      @(posedge clk); #1;
      seen = b3.resp_valid;
      rst3 = 1'b1;
      @(posedge clk); #1;
      rst3 = 1'b0;
      check("rst_wait_ready", 32'(b3.req_ready), 32'd1);
      repeat (6) begin seen |= b3.resp_valid; @(posedge clk); #1; end
      check("rst_wait_no_resp", 32'(seen), 32'd0);
      xact(1, 1, 0, SZ_WORD, 0, 32'h40, 32'h0, 0, got);
      check("rst_wait_prior", got, prior);

      prior = {mref[1][68], mref[1][69], mref[1][70], mref[1][71]};
      drive(1, 1'b1, 1'b0, 1'b1, SZ_WORD, 1'b0, 32'h44, 32'h0BADF00D);
      n = 0;
      while (!b3.req_ready && n < 50) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      drive(1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
      n = 0;
      while (!b3.resp_valid && n < 50) begin @(posedge clk); #1; n++; end
      check("rst_resp_lat", 32'(n), 32'd3);
      rst3 = 1'b1;
      @(posedge clk); #1;
      rst3 = 1'b0;
      check("rst_resp_rv", 32'(b3.resp_valid), 32'd0);
      xact(1, 1, 0, SZ_WORD, 0, 32'h44, 32'h0, 0, got);
      check("rst_resp_prior", got, prior);

      for (int s = 0; s < 2; s++) begin
         for (int i = 0; i < 120; i++) begin
            r  = $urandom_range(0, 9);
            rd = (r < 5);
            wr = (r >= 5) && (r < 9);
            if (r == 9) begin b = 1'($urandom_range(0, 1)); rd = b; wr = b; end
            sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
               if (sz == SZ_HALF) a[0] = 1'b0;
               if (sz == SZ_WORD) a[1:0] = 2'b00;
            end
            xact(s, rd, wr, sz, 1'($urandom), a, $urandom, 1'b0, got);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
